// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU result stage: datapath width, result-mux
// select codes and the bit positions inside the 4-bit flag vector.
package alu32_pkg;

   localparam int unsigned ALU_WIDTH = 32;
   localparam int unsigned OP_W      = 3;
   localparam int unsigned FLAG_W    = 4;
   localparam int unsigned PTR_W     = 1;
   localparam int unsigned CNT_W     = 2;

   // Result-mux select codes
   localparam logic [OP_W-1:0] OP_AND = 3'd0;
   localparam logic [OP_W-1:0] OP_OR  = 3'd1;
   localparam logic [OP_W-1:0] OP_ADD = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR = 3'd3;
   localparam logic [OP_W-1:0] OP_NOR = 3'd4;
   localparam logic [OP_W-1:0] OP_SLL = 3'd5;
   localparam logic [OP_W-1:0] OP_SUB = 3'd6;
   localparam logic [OP_W-1:0] OP_SLT = 3'd7;

   // Flag vector layout: {carry, negative, zero, parity}
   localparam int unsigned FLAG_PARITY = 0;
   localparam int unsigned FLAG_ZERO   = 1;
   localparam int unsigned FLAG_NEG    = 2;
   localparam int unsigned FLAG_CARRY  = 3;

   // Only the adder path produces a meaningful carry-out
   function automatic logic op_has_carry(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu32_flag_gen.sv
// Combinational flag generator for a selected ALU result.
// Ports: data (result word), op (select code), cout (adder carry-out),
//        flags_c ({carry, negative, zero, parity}).
module alu32_flag_gen
   import alu32_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0]  data,
   input  logic [OP_W-1:0]   op,
   input  logic              cout,
   output logic [FLAG_W-1:0] flags_c
);

   // Flag bits derived from the word itself plus gated carry
   always_comb begin
      flags_c              = '0;
      flags_c[FLAG_CARRY]  = op_has_carry(op) ? cout : 1'b0;
      flags_c[FLAG_NEG]    = data[WIDTH-1];
      flags_c[FLAG_ZERO]   = (data == '0);
      flags_c[FLAG_PARITY] = ^data;
   end

endmodule

// File: rtl/alu32_result_stage.sv
// Two-entry result buffer between the ALU result mux and its consumer.
// Captures the result word, its select tag and derived flags, and presents
// the oldest entry with a valid/ready handshake on both sides.
// Ports: clk, reset (sync, active-high);
//        in_valid/in_ready/in_data/in_op/in_cout (upstream side);
//        out_valid/out_ready/out_data/out_op/out_flags (downstream side).
module alu32_result_stage
   import alu32_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [OP_W-1:0]   in_op,
   input  logic              in_cout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [OP_W-1:0]   out_op,
   output logic [FLAG_W-1:0] out_flags
);

   logic [WIDTH-1:0]  data_q  [DEPTH];
   logic [WIDTH-1:0]  data_d  [DEPTH];
   logic [OP_W-1:0]   op_q    [DEPTH];
   logic [OP_W-1:0]   op_d    [DEPTH];
   logic [FLAG_W-1:0] flags_q [DEPTH];
   logic [FLAG_W-1:0] flags_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   logic [FLAG_W-1:0] in_flags_c;
   logic              push_c;
   logic              pop_c;

   alu32_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .data    (in_data),
      .op      (in_op),
      .cout    (in_cout),
      .flags_c (in_flags_c)
   );

   // Handshake status comes from registered occupancy only
   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);

   // Head entry is read straight out of the storage flops
   assign out_data  = data_q[rd_ptr_q];
   assign out_op    = op_q[rd_ptr_q];
   assign out_flags = flags_q[rd_ptr_q];

   // Next-state: storage write, pointer advance, occupancy update
   always_comb begin
      data_d   = data_q;
      op_d     = op_q;
      flags_d  = flags_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_c   = in_valid && in_ready;
      pop_c    = out_ready && out_valid;

      if (push_c) begin
         data_d[wr_ptr_q]  = in_data;
         op_d[wr_ptr_q]    = in_op;
         flags_d[wr_ptr_q] = in_flags_c;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end

      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards any buffered entries
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i]  <= '0;
            op_q[i]    <= '0;
            flags_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         data_q   <= data_d;
         op_q     <= op_d;
         flags_q  <= flags_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
